// File: rtl/stable_hold_driver_if.sv
// stable_hold_driver_if: valid/ready request channel feeding stable_hold_driver
// The producer (master) offers req_data under req_valid; the driver (slave) answers with req_ready.
interface stable_hold_driver_if #(
    parameter int WIDTH = 1
);
    logic             req_valid;
    logic [WIDTH-1:0] req_data;
    logic             req_ready;
    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/stable_hold_driver.sv
// stable_hold_driver: drives sig_out from a valid/ready channel, holding each new value >= MIN_HOLD edges
// Define STABLE_CHECK_EN to add a shadow edge counter that raises a sticky stab_err on an early change.
module stable_hold_driver #(
    parameter int WIDTH    = 1,
    parameter int MIN_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    stable_hold_driver_if.slave    req,
    output logic [WIDTH-1:0]       sig_out,
    output logic                   changed,
    output logic [CNT_W-1:0]       hold_cnt,
    output logic                   stab_err
);
    localparam logic [0:0]       IDLE  = 1'b0;
    localparam logic [0:0]       HOLD  = 1'b1;
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(MIN_HOLD - 1);
    localparam bit               MULTI = MIN_HOLD > 1;

    logic [0:0] state;
    logic       accept;
    logic       upd;

    assign req.req_ready = state == IDLE;
    assign accept        = req.req_valid & req.req_ready;
    assign upd           = accept && (req.req_data != sig_out);

    // With MIN_HOLD==1 the block never leaves IDLE, allowing a change on every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sig_out  <= '0;
            changed  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            changed <= upd;
            if (state == IDLE) begin
                if (upd) sig_out <= req.req_data;
                if (upd && MULTI) begin
                    hold_cnt <= LOAD;
                    state    <= HOLD;
                end
            end else begin
                if (hold_cnt != '0) hold_cnt <= hold_cnt - CNT_W'(1);
                if (hold_cnt <= CNT_W'(1)) state <= IDLE;
            end
        end
    end

`ifdef STABLE_CHECK_EN
    logic [CNT_W-1:0] shadow;
    // shadow = edges since the last change, counting the change edge itself, saturating at MIN_HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= CNT_W'(MIN_HOLD);
            stab_err <= 1'b0;
        end else begin
            shadow <= upd ? CNT_W'(1) : (shadow < CNT_W'(MIN_HOLD) ? shadow + CNT_W'(1) : shadow);
            if (upd && shadow < CNT_W'(MIN_HOLD)) stab_err <= 1'b1;
        end
    end
`else
    assign stab_err = 1'b0;
`endif
endmodule

// File: tb/tb_stable_hold_driver.sv
// tb_stable_hold_driver: random and directed traffic on MIN_HOLD=4 and MIN_HOLD=1 instances,
// checked every cycle against a time-since-last-change model.
module tb_stable_hold_driver;
    localparam int CW = 8;
    localparam int MH [2] = '{4, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic v [2];
    logic d [2];
    logic rd [2];
    logic so [2];
    logic ch [2];
    logic se [2];
    logic [CW-1:0] hc [2];

    stable_hold_driver_if #(.WIDTH(1)) r0 ();
    stable_hold_driver_if #(.WIDTH(1)) r1 ();
    assign r0.req_valid = v[0];
    assign r0.req_data  = d[0];
    assign r1.req_valid = v[1];
    assign r1.req_data  = d[1];
    assign rd[0] = r0.req_ready;
    assign rd[1] = r1.req_ready;

    stable_hold_driver #(.WIDTH(1), .MIN_HOLD(4), .CNT_W(CW)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(r0), .sig_out(so[0]), .changed(ch[0]),
        .hold_cnt(hc[0]), .stab_err(se[0]));
    stable_hold_driver #(.WIDTH(1), .MIN_HOLD(1), .CNT_W(CW)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(r1), .sig_out(so[1]), .changed(ch[1]),
        .hold_cnt(hc[1]), .stab_err(se[1]));

    // Model: current value, edge index of the last change, and whether any change happened since reset.
    logic m_sig [2];
    bit   m_chg [2];
    bit   m_acc [2];
    bit   m_any [2];
    int   m_last [2];
    int   n = 0;
    bit   cmp_en = 0;
    int   n_chk = 0;
    int   n_err = 0;

    function automatic int exp_hold(int i);
        int r;
        r = m_any[i] ? MH[i] - 1 - (n - m_last[i]) : 0;
        return r > 0 ? r : 0;
    endfunction

    task automatic chk(string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sig[i] = 1'b0;
            m_chg[i] = 0;
            m_acc[i] = 0;
            m_any[i] = 0;
            m_last[i] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0;
            m_chg[i] = 0;
            if (rst_n && v[i] && (!m_any[i] || n - m_last[i] >= MH[i])) begin
                m_acc[i] = 1;
                if (d[i] != m_sig[i]) begin
                    m_chg[i] = 1;
                    m_sig[i] = d[i];
                    m_last[i] = n;
                    m_any[i] = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("sig_out%0d", i), so[i], m_sig[i]);
                chk($sformatf("changed%0d", i), ch[i], m_chg[i]);
                chk($sformatf("hold_cnt%0d", i), hc[i], exp_hold(i));
                chk($sformatf("req_ready%0d", i), rd[i], exp_hold(i) == 0);
                chk($sformatf("stab_err%0d", i), se[i], 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic seqv [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int   exp_off [5] = '{0, 4, 8, 12, 13};
    logic exp_ch [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int   acc_n [5];
    logic acc_ch [5];
    bit   pend [2];

    initial begin
        v = '{1'b0, 1'b0};
        d = '{1'b0, 1'b0};
        #2 rst_n = 1'b0;
        model_reset();
        cmp_en = 1;
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_sig", so[0], 0);
        chk("rst_chg", ch[0], 0);
        chk("rst_hold", hc[0], 0);
        chk("rst_ready", rd[0], 1);
        chk("rst_stab", se[0], 0);

        // Directed sequence 1,0,1,1,0 with req_valid always high on the MIN_HOLD=4 instance.
        for (int k = 0; k < 5; k++) begin
            int t;
            v[0] = 1'b1;
            d[0] = seqv[k];
            t = 0;
            do begin
                step();
                t++;
            end while (!m_acc[0] && t < 20);
            chk("seq_accept_in_time", t < 20, 1);
            chk("seq_value", so[0], seqv[k]);
            acc_n[k] = n;
            acc_ch[k] = ch[0];
            if (k == 0) begin
                chk("first_hold", hc[0], 3);
                chk("first_ready", rd[0], 0);
            end
        end
        v[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("seq_edge", acc_n[k] - acc_n[0], exp_off[k]);
            chk("seq_changed", acc_ch[k], exp_ch[k]);
        end

        // MIN_HOLD=1: toggle every cycle.
        v[1] = 1'b1;
        repeat (10) begin
            d[1] = ~m_sig[1];
            step();
            chk("toggle_changed", ch[1], 1);
            chk("toggle_ready", rd[1], 1);
        end
        v[1] = 1'b0;
        repeat (5) step();

        // Asynchronous reset in the middle of a hold.
        v[0] = 1'b1;
        d[0] = ~so[0];
        step();
        v[0] = 1'b0;
        step();
        chk("mid_hold_cnt", hc[0], 2);
        chk("mid_hold_sig", so[0], 1);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_sig", so[0], 0);
        chk("async_hold", hc[0], 0);
        chk("async_ready", rd[0], 1);
        repeat (3) step();
        rst_n = 1'b1;

        // Random legal traffic: data is held stable while a request is pending.
        pend = '{0, 0};
        repeat (3000) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) begin
                    v[i] = $urandom_range(0, 3) != 0;
                    d[i] = 1'($urandom_range(0, 1));
                    pend[i] = v[i];
                end
            end
            step();
            for (int i = 0; i < 2; i++) if (m_acc[i]) pend[i] = 0;
        end
        v = '{1'b0, 1'b0};
        repeat (5) step();

`ifdef STABLE_CHECK_EN
        chk("stab_clean", se[0], 0);
        cmp_en = 0;
        v[0] = 1'b1;
        d[0] = ~so[0];
        step();
        v[0] = 1'b0;
        force dut0.hold_cnt = '0;
        step();
        v[0] = 1'b1;
        d[0] = ~so[0];
        step();
        v[0] = 1'b0;
        chk("stab_set", se[0], 1);
        release dut0.hold_cnt;
        repeat (5) step();
        chk("stab_sticky", se[0], 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("stab_cleared", se[0], 0);
        repeat (2) step();
        rst_n = 1'b1;
        cmp_en = 1;
        repeat (3) step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
